// File: rtl/pipelined_rca_if.sv
// rtl/pipelined_rca_if.sv - Operand/result handshake bundle for pipelined_rca
interface pipelined_rca_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             last_bit_ci;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, last_bit_ci, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, last_bit_ci, overflow, zero
    );
endinterface

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - Pipelined ripple-carry add/subtract, one CHUNK-bit slice per stage
module pipelined_rca #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clock,
    input  logic           reset,
    pipelined_rca_if.slave bus
);
    localparam int S = WIDTH / CHUNK;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;

    logic [WIDTH-1:0] q_a     [S];
    logic [WIDTH-1:0] q_b     [S];
    logic [WIDTH-1:0] q_sum   [S];
    logic             q_carry [S];
    logic             q_valid [S];

    logic [WIDTH-1:0] d_sum   [S];
    logic             d_carry [S];
    logic [CHUNK:0]   slice;

    logic [WIDTH-1:0] last_sum;
    logic             last_co;
    logic             last_ci;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign ci_eff       = bus.c_in ^ bus.sub;

    // Each stage adds only its own slice; lower slices ride along already summed.
    always_comb begin
        slice = {1'b0, bus.a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]} + {{CHUNK{1'b0}}, ci_eff};
        d_sum[0]              = '0;
        d_sum[0][CHUNK-1:0]   = slice[CHUNK-1:0];
        d_carry[0]            = slice[CHUNK];
        for (int k = 1; k < S; k++) begin
            slice = {1'b0, q_a[k-1][k*CHUNK +: CHUNK]} + {1'b0, q_b[k-1][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, q_carry[k-1]};
            d_sum[k]                   = q_sum[k-1];
            d_sum[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
            d_carry[k]                 = slice[CHUNK];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < S; k++) begin
                q_valid[k] <= 1'b0;
            end
        end else if (adv) begin
            q_valid[0] <= bus.in_valid;
            q_a[0]     <= bus.a;
            q_b[0]     <= b_eff;
            q_sum[0]   <= d_sum[0];
            q_carry[0] <= d_carry[0];
            for (int k = 1; k < S; k++) begin
                q_valid[k] <= q_valid[k-1];
                q_a[k]     <= q_a[k-1];
                q_b[k]     <= q_b[k-1];
                q_sum[k]   <= d_sum[k];
                q_carry[k] <= d_carry[k];
            end
        end
    end

    // Carry into the MSB recovered from the MSB's own sum and operand bits.
    assign last_sum = q_sum[S-1];
    assign last_co  = q_carry[S-1];
    assign last_ci  = last_sum[WIDTH-1] ^ q_a[S-1][WIDTH-1] ^ q_b[S-1][WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.sum         <= '0;
            bus.c_out       <= 1'b0;
            bus.last_bit_ci <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.zero        <= 1'b1;
        end else if (adv) begin
            bus.out_valid <= q_valid[S-1];
            if (q_valid[S-1]) begin
                bus.sum         <= last_sum;
                bus.c_out       <= last_co;
                bus.last_bit_ci <= last_ci;
                bus.overflow    <= last_co ^ last_ci;
                bus.zero        <= (last_sum == '0);
            end
        end
    end
endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - Self-checking bench for pipelined_rca at three geometries
module tb_pipelined_rca;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic iv; logic ordy; logic ci; logic sub; logic [31:0] a; logic [31:0] b;
    } drv_t;
    typedef struct packed {
        logic iv; logic ir; logic ov; logic ordy; logic ci; logic sub;
        logic [31:0] a; logic [31:0] b; logic [35:0] res;
    } obs_t;
    typedef struct { logic [35:0] res; int t; } exp_t;
    typedef struct {
        logic [15:0] a; logic [15:0] b; logic ci; logic sub;
        logic [15:0] sum; logic co; logic lci; logic ovf; logic z;
    } vec_t;

    localparam int WD [3] = '{16, 32, 8};
    localparam int SD [3] = '{4, 4, 1};

    drv_t drv [3];
    obs_t obs [3];
    exp_t exp_q [3][$];
    int   n_acc [3];
    bit   lat_chk [3];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs [6];

    pipelined_rca_if #(.WIDTH(16)) if16();
    pipelined_rca_if #(.WIDTH(32)) if32();
    pipelined_rca_if #(.WIDTH(8))  if8();

    pipelined_rca #(.WIDTH(16), .CHUNK(4)) u_rca16 (.clock(clk), .reset(rst), .bus(if16));
    pipelined_rca #(.WIDTH(32), .CHUNK(8)) u_rca32 (.clock(clk), .reset(rst), .bus(if32));
    pipelined_rca #(.WIDTH(8),  .CHUNK(8)) u_rca8  (.clock(clk), .reset(rst), .bus(if8));

    assign if16.in_valid = drv[0].iv;  assign if16.out_ready = drv[0].ordy;
    assign if16.c_in     = drv[0].ci;  assign if16.sub       = drv[0].sub;
    assign if16.a        = drv[0].a[15:0]; assign if16.b     = drv[0].b[15:0];
    assign if32.in_valid = drv[1].iv;  assign if32.out_ready = drv[1].ordy;
    assign if32.c_in     = drv[1].ci;  assign if32.sub       = drv[1].sub;
    assign if32.a        = drv[1].a;   assign if32.b         = drv[1].b;
    assign if8.in_valid  = drv[2].iv;  assign if8.out_ready  = drv[2].ordy;
    assign if8.c_in      = drv[2].ci;  assign if8.sub        = drv[2].sub;
    assign if8.a         = drv[2].a[7:0];  assign if8.b      = drv[2].b[7:0];

    assign obs[0] = {if16.in_valid, if16.in_ready, if16.out_valid, if16.out_ready, if16.c_in, if16.sub,
                     32'(if16.a), 32'(if16.b), 32'(if16.sum), if16.c_out, if16.last_bit_ci, if16.overflow, if16.zero};
    assign obs[1] = {if32.in_valid, if32.in_ready, if32.out_valid, if32.out_ready, if32.c_in, if32.sub,
                     if32.a, if32.b, if32.sum, if32.c_out, if32.last_bit_ci, if32.overflow, if32.zero};
    assign obs[2] = {if8.in_valid, if8.in_ready, if8.out_valid, if8.out_ready, if8.c_in, if8.sub,
                     32'(if8.a), 32'(if8.b), 32'(if8.sum), if8.c_out, if8.last_bit_ci, if8.overflow, if8.zero};

    // Reference: whole-word integer arithmetic; carry into MSB from the sum of the lower w-1 bits.
    function automatic logic [35:0] model(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sub);
        logic [63:0] m, be, full, low;
        logic [31:0] s;
        logic co, lci;
        m    = (64'd1 << w) - 64'd1;
        be   = sub ? (~{32'd0, b}) & m : {32'd0, b};
        full = {32'd0, a} + be + 64'(ci ^ sub);
        low  = ({32'd0, a} & (m >> 1)) + (be & (m >> 1)) + 64'(ci ^ sub);
        s    = 32'(full & m);
        co   = full[w];
        lci  = low[w-1];
        return {s, co, lci, co ^ lci, s == 32'd0};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic sample();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                exp_q[d].delete();
            end else begin
                if (obs[d].ov && obs[d].ordy) begin
                    check($sformatf("dut%0d_result_pending", d), 64'(exp_q[d].size() != 0), 64'd1);
                    if (exp_q[d].size() != 0) begin
                        e = exp_q[d].pop_front();
                        check($sformatf("dut%0d_result", d), 64'(obs[d].res), 64'(e.res));
                        if (lat_chk[d]) check($sformatf("dut%0d_latency", d), 64'(cyc - e.t), 64'(SD[d]));
                    end
                end
                if (obs[d].iv && obs[d].ir) begin
                    exp_q[d].push_back('{model(WD[d], obs[d].a, obs[d].b, obs[d].ci, obs[d].sub), cyc + 1});
                    n_acc[d]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int i;
        int start [3];
        logic [31:0] got [$];

        for (int d = 0; d < 3; d++) begin
            drv[d]     = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
            lat_chk[d] = 1'b1;
            n_acc[d]   = 0;
        end
        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_out_valid", 64'(obs[0].ov), 64'd0);
        check("reset_flags", 64'(obs[0].res), 64'h1);
        check("reset_in_ready", 64'(obs[0].ir), 64'd1);
        check("reset_out_valid_w32", 64'(obs[1].ov), 64'd0);
        check("reset_out_valid_w8", 64'(obs[2].ov), 64'd0);

        for (int v = 0; v < 6; v++) begin
            drv[0].iv = 1'b1; drv[0].a = 32'(vecs[v].a); drv[0].b = 32'(vecs[v].b);
            drv[0].ci = vecs[v].ci; drv[0].sub = vecs[v].sub;
            tick();
            drv[0].iv = 1'b0;
            tick(); tick(); tick();
            check($sformatf("vec%0d_not_early", v), 64'(obs[0].ov), 64'd0);
            tick();
            check($sformatf("vec%0d_valid", v), 64'(obs[0].ov), 64'd1);
            check($sformatf("vec%0d_result", v), 64'(obs[0].res),
                  64'({16'h0, vecs[v].sum, vecs[v].co, vecs[v].lci, vecs[v].ovf, vecs[v].z}));
            tick();
        end

        lat_chk[0] = 1'b0;
        drv[0].ci = 1'b0; drv[0].sub = 1'b0;
        i = 0;
        got.delete();
        for (int c = 0; c < 300 && got.size() < 8; c++) begin
            drv[0].ordy = 1'($urandom_range(0, 1));
            drv[0].iv   = (i < 8);
            drv[0].a    = 32'(i);
            drv[0].b    = 32'(3 * i);
            #1;
            check("stall_in_ready", 64'(obs[0].ir), 64'(!(obs[0].ov && !obs[0].ordy)));
            if (obs[0].ov && obs[0].ordy) got.push_back(obs[0].res[35:4]);
            if (obs[0].iv && obs[0].ir) i++;
            tick();
        end
        drv[0].iv = 1'b0; drv[0].ordy = 1'b1;
        check("stream_count", 64'(got.size()), 64'd8);
        for (int j = 0; j < got.size(); j++) check($sformatf("stream_item%0d", j), 64'(got[j]), 64'(4 * j));
        tick();
        lat_chk[0] = 1'b1;

        for (int k = 0; k < 5; k++) begin
            drv[0].iv = 1'b1; drv[0].a = 32'(k + 1); drv[0].b = 32'(k + 2);
            tick();
        end
        drv[0].iv = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("flush_out_valid", 64'(obs[0].ov), 64'd0);
        check("flush_sum", 64'(obs[0].res[35:4]), 64'd0);
        check("flush_in_ready", 64'(obs[0].ir), 64'd1);
        got.delete();
        drv[0].iv = 1'b1; drv[0].a = 32'd100; drv[0].b = 32'd200;
        tick();
        drv[0].a = 32'd7; drv[0].b = 32'd8;
        tick();
        drv[0].iv = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (obs[0].ov && obs[0].ordy) got.push_back(obs[0].res[35:4]);
            tick();
        end
        check("post_reset_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            check("post_reset_first", 64'(got[0]), 64'd300);
            check("post_reset_second", 64'(got[1]), 64'd15);
        end

        for (int d = 0; d < 3; d++) begin
            start[d] = n_acc[d];
            drv[d].ordy = 1'b1;
        end
        i = 0;
        while (i < 4000 && (n_acc[0] - start[0] < 1000 || n_acc[1] - start[1] < 1000 || n_acc[2] - start[2] < 1000)) begin
            for (int d = 0; d < 3; d++) begin
                drv[d].iv  = (n_acc[d] - start[d] < 1000) && ($urandom_range(0, 3) != 0);
                drv[d].a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                drv[d].b   = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
                drv[d].ci  = 1'($urandom_range(0, 1));
                drv[d].sub = 1'($urandom_range(0, 1));
            end
            tick();
            i++;
        end
        for (int d = 0; d < 3; d++) drv[d].iv = 1'b0;
        repeat (8) tick();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_random_accepted", d), 64'(n_acc[d] - start[d]), 64'd1000);
            check($sformatf("dut%0d_drained", d), 64'(exp_q[d].size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
